mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control unit for the MIPS datapath: a Moore state machine that sequences instruction fetch, decode, execute, memory and writeback over several clock cycles. It drives the PC write enable, PC source selection, instruction-register load, memory, register-file and ALU selects. A retired-instruction counter supports performance checks. It sits beside the shared-memory multicycle datapath and is fed the opcode from the instruction register and the ALU zero flag.

## Interface
- RETIRE_W, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces FETCH state and clears the counter
- op  in  6  opcode, instr[31:26], from the instruction register
- zero  in  1  ALU zero flag
- pc_en  out  1  PC load enable = pc_write | (branch_taken)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data-memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = memory data
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- alu_op  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- retired  out  RETIRE_W  count of completed instructions

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010, bne 000101 (only when configured).
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - lw/sw → MEMADR; R → EXEC; beq/bne → BRANCH; addi → ADDIEX; j → JUMP.
  - Any other opcode → FETCH with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw → MEMRD; sw → MEMWR.
- MEMRD: iord=1 → MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
- MEMWR: iord=1, mem_write=1 → FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01. Taken when (beq & zero) | (bne & ~zero). pc_en=taken. → FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 → FETCH.
- JUMP: pc_src=10, pc_write=1 → FETCH.
- Every control output not listed for a state is 0.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^RETIRE_W. Illegal opcodes do not count.
- op is sampled in DECODE and MEMADR only. The IR holds it stable.

## Timing
- Reset values: state=FETCH, so outputs show FETCH decode (ir_write=1, pc_en=1, alu_src_b=01, all others 0); retired=0; illegal_op=0.
- Outputs are combinational from state only (Moore), except pc_en in BRANCH, which also depends on zero and the latched opcode.
- Cycles per instruction:
  - lw 5
  - sw 4, R 4, addi 4
  - beq/bne 3, j 3
  - illegal 2
- Reset asserted mid-instruction aborts it immediately: no retire, next state after release is FETCH.
- retired updates on the same edge that enters FETCH.

## Configuration
- MC_BNE_EN defined: opcode 000101 decodes to BRANCH with inverted zero sense.
- MC_BNE_EN undefined: 000101 is illegal (illegal_op pulse, return to FETCH).

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum
  - opcode localparams
  - alu_op, alu_src_b and pc_src encodings
- Sub-module mc_ctrl_decode: combinational state(+zero, op) → control-vector decoder. The FSM holds only the state register, next-state logic and the counter.

## Test plan
- Reset released, op=100011 held: states FETCH→DECODE→MEMADR→MEMRD→MEMWB→FETCH. reg_write=1, mem_to_reg=1 in cycle 5. retired=1.
- sw then R-type (op 101011, 000000): mem_write=1 in cycle 4; reg_write=1 with reg_dst=1 in cycle 8. retired=2 after 8 cycles.
- beq with zero=1: pc_en=1, pc_src=01 in cycle 3. With zero=0: pc_en=0 in cycle 3. Both retire.
- bne (000101) with zero=0: pc_en=1 under MC_BNE_EN. Without the macro: illegal_op=1 in cycle 2, back in FETCH at cycle 3, retired unchanged.
- j: pc_src=10, pc_en=1 in cycle 3. addi: reg_write=1, reg_dst=0, alu_src_b=10 across cycles 3–4.
- reset asserted during MEMRD: state=FETCH and outputs at reset values immediately, retired=0. Preload RETIRE_W=4 with 15 retires, then one more: retired wraps to 0.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// ============================================================================
// Module : mc_ctrl_pkg
// Shared state encoding, opcodes and select encodings for the multicycle
// control unit. Optional feature macro: MC_BNE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] c_SRCB_B     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // Successor of DECODE; FETCH doubles as the "unsupported opcode" answer.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            c_OP_LW, c_OP_SW: nxt = S_MEMADR;
            c_OP_RTYPE:       nxt = S_EXEC;
            c_OP_BEQ:         nxt = S_BRANCH;
`ifdef MC_BNE_EN
            c_OP_BNE:         nxt = S_BRANCH;
`endif
            c_OP_ADDI:        nxt = S_ADDIEX;
            c_OP_J:           nxt = S_JUMP;
            default:          nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
// ============================================================================
// Module : mc_control_fsm_if
// Control bundle between the multicycle control unit and its datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mc_control_fsm_if #(
    parameter int RETIRE_W = 32
);
    logic [5:0]          op;
    logic                zero;
    logic                pc_en;
    logic                iord;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic                illegal_op;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  op, zero,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal_op, retired
    );

    modport slave (
        output op, zero,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal_op, retired
    );
endinterface

`default_nettype wire

// File: rtl/mc_control_fsm_decode.sv
// ============================================================================
// Module : mc_ctrl_decode
// Combinational state -> control-vector decoder. Optional macro: MC_BNE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       bne_i,
    output logic       pc_en_o,
    output logic       iord_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic       illegal_op_o
);

    always_comb begin
        pc_en_o      = 1'b0;
        iord_o       = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = c_SRCB_B;
        alu_op_o     = c_ALUOP_ADD;
        pc_src_o     = c_PCSRC_ALU;
        illegal_op_o = 1'b0;
        case (state_i)
            S_FETCH: begin
                ir_write_o  = 1'b1;
                pc_en_o     = 1'b1;
                alu_src_b_o = c_SRCB_FOUR;
            end
            S_DECODE: begin
                alu_src_b_o  = c_SRCB_IMMSH;
                illegal_op_o = (decode_next(op_i) == S_FETCH);
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = c_SRCB_IMM;
            end
            S_MEMRD: iord_o = 1'b1;
            S_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            S_MEMWR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = c_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = c_ALUOP_SUB;
                pc_src_o    = c_PCSRC_ALUOUT;
                pc_en_o     = bne_i ? ~zero_i : zero_i;
            end
            S_ADDIWB: reg_write_o = 1'b1;
            S_JUMP: begin
                pc_src_o = c_PCSRC_JUMP;
                pc_en_o  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module : mc_control_fsm
// Multicycle MIPS control FSM with retired-instruction counter.
// Optional macro: MC_BNE_EN (bne support). Revision: 1.0
// ============================================================================
`default_nettype none

module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    mc_control_fsm_if.master    bus
);

    state_t              state_q, state_d;
    logic                bne_q;
    logic [RETIRE_W-1:0] retired_q;
    logic                w_retire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = decode_next(bus.op);
            S_MEMADR: state_d = (bus.op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Only completed instructions return to FETCH from beyond DECODE.
    assign w_retire = (state_d == S_FETCH) && (state_q != S_FETCH)
                   && (state_q != S_DECODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            bne_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                bne_q <= (bus.op == c_OP_BNE);
            if (w_retire)
                retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    mc_ctrl_decode u_decode (
        .state_i      (state_q),
        .op_i         (bus.op),
        .zero_i       (bus.zero),
        .bne_i        (bne_q),
        .pc_en_o      (bus.pc_en),
        .iord_o       (bus.iord),
        .mem_write_o  (bus.mem_write),
        .ir_write_o   (bus.ir_write),
        .reg_dst_o    (bus.reg_dst),
        .mem_to_reg_o (bus.mem_to_reg),
        .reg_write_o  (bus.reg_write),
        .alu_src_a_o  (bus.alu_src_a),
        .alu_src_b_o  (bus.alu_src_b),
        .alu_op_o     (bus.alu_op),
        .pc_src_o     (bus.pc_src),
        .illegal_op_o (bus.illegal_op)
    );

    assign bus.retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module : tb_mc_control_fsm
// Self-checking bench: 32-bit and 4-bit counter instances, same stimulus.
// Honours MC_BNE_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

    typedef enum int {P_F, P_D, P_MA, P_MR, P_MW, P_WR, P_EX, P_AW,
                      P_BR, P_AE, P_AI, P_J} phase_t;
    typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_BNE, K_ADDI, K_J, K_ILL} kind_t;

    logic        clk;
    logic        reset;
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic [31:0] cnt      = 0;

    mc_control_fsm_if #(.RETIRE_W(32)) bus32 ();
    mc_control_fsm_if #(.RETIRE_W(4))  bus4 ();

    mc_control_fsm #(.RETIRE_W(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    mc_control_fsm #(.RETIRE_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

    logic [14:0] ctl32, ctl4;
    assign ctl32 = {bus32.pc_en, bus32.iord, bus32.mem_write, bus32.ir_write,
                    bus32.reg_dst, bus32.mem_to_reg, bus32.reg_write,
                    bus32.alu_src_a, bus32.alu_src_b, bus32.alu_op,
                    bus32.pc_src, bus32.illegal_op};
    assign ctl4  = {bus4.pc_en, bus4.iord, bus4.mem_write, bus4.ir_write,
                    bus4.reg_dst, bus4.mem_to_reg, bus4.reg_write,
                    bus4.alu_src_a, bus4.alu_src_b, bus4.alu_op,
                    bus4.pc_src, bus4.illegal_op};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic kind_t classify(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
`ifdef MC_BNE_EN
            6'b000101: return K_BNE;
`endif
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    // Expected control word for one cycle of an instruction of kind k.
    function automatic logic [14:0] exp_ctl(input phase_t p, input logic z, input kind_t k);
        logic pc_en, iord, mw, irw, rdst, m2r, rw, sa, ill;
        logic [1:0] sb, aop, psrc;
        {pc_en, iord, mw, irw, rdst, m2r, rw, sa, ill} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (p)
            P_F:  begin irw = 1; pc_en = 1; sb = 2'b01; end
            P_D:  begin sb = 2'b11; ill = (k == K_ILL); end
            P_MA: begin sa = 1; sb = 2'b10; end
            P_MR: iord = 1;
            P_MW: begin m2r = 1; rw = 1; end
            P_WR: begin iord = 1; mw = 1; end
            P_EX: begin sa = 1; aop = 2'b10; end
            P_AW: begin rdst = 1; rw = 1; end
            P_BR: begin
                sa = 1; aop = 2'b01; psrc = 2'b01;
                pc_en = ((k == K_BEQ) && z) || ((k == K_BNE) && !z);
            end
            P_AE: begin sa = 1; sb = 2'b10; end
            P_AI: rw = 1;
            P_J:  begin psrc = 2'b10; pc_en = 1; end
            default: ;
        endcase
        return {pc_en, iord, mw, irw, rdst, m2r, rw, sa, sb, aop, psrc, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic [14:0] exp);
        check("ctl32", {17'd0, ctl32}, {17'd0, exp});
        check("ctl4",  {17'd0, ctl4},  {17'd0, exp});
        check("ret32", bus32.retired, cnt);
        check("ret4",  {28'd0, bus4.retired}, cnt & 32'hF);
    endtask

    // One cycle: choose zero (0/1 fixed, 2 random), check, advance a clock.
    task automatic step(input phase_t p, input kind_t k, input int zmode);
        logic z;
        z = (zmode == 2) ? logic'($urandom_range(0, 1)) : logic'(zmode[0]);
        bus32.zero = z;
        bus4.zero  = z;
        #1;
        check_all(exp_ctl(p, z, k));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] opc, input int zmode);
        kind_t  k;
        phase_t ph[$];
        k = classify(opc);
        case (k)
            K_LW:         ph = '{P_F, P_D, P_MA, P_MR, P_MW};
            K_SW:         ph = '{P_F, P_D, P_MA, P_WR};
            K_R:          ph = '{P_F, P_D, P_EX, P_AW};
            K_BEQ, K_BNE: ph = '{P_F, P_D, P_BR};
            K_ADDI:       ph = '{P_F, P_D, P_AE, P_AI};
            K_J:          ph = '{P_F, P_D, P_J};
            default:      ph = '{P_F, P_D};
        endcase
        bus32.op = opc;
        bus4.op  = opc;
        foreach (ph[i]) begin
            step(ph[i], k, zmode);
        end
        if (k != K_ILL) cnt = cnt + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        cnt = 0;
        check_all(exp_ctl(P_F, 1'b0, K_ILL));
        reset = 1'b0;
        #1;
    endtask

    logic [5:0] op_tab [8];

    initial begin
        op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                   6'b000101, 6'b001000, 6'b000010, 6'b111111};
        reset = 1'b1;
        bus32.op = 6'd0; bus4.op = 6'd0;
        bus32.zero = 1'b0; bus4.zero = 1'b0;
        @(posedge clk);
        #1;
        check_all(exp_ctl(P_F, 1'b0, K_ILL));
        reset = 1'b0;
        #1;

        // Directed: lw, sw, R, beq taken/not, bne, j, addi, illegal
        run_instr(6'b100011, 2);
        run_instr(6'b101011, 2);
        run_instr(6'b000000, 2);
        run_instr(6'b000100, 1);
        run_instr(6'b000100, 0);
        run_instr(6'b000101, 0);
        run_instr(6'b000101, 1);
        run_instr(6'b000010, 2);
        run_instr(6'b001000, 2);
        run_instr(6'b111111, 2);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] o;
            int idx;
            idx = $urandom_range(0, 7);
            o = (idx == 7) ? 6'($urandom) : op_tab[idx];
            run_instr(o, 2);
        end

        // Abort an lw while in MEMRD
        do_reset();
        bus32.op = 6'b100011; bus4.op = 6'b100011;
        step(P_F,  K_LW, 2);
        step(P_D,  K_LW, 2);
        step(P_MA, K_LW, 2);
        do_reset();
        run_instr(6'b000000, 2);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 15; i++) run_instr(6'b000010, 2);
        check("wrap_pre", {28'd0, bus4.retired}, 32'd15);
        run_instr(6'b000010, 2);
        check("wrap_post", {28'd0, bus4.retired}, 32'd0);
        check("ret32_16", bus32.retired, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
